// File: rtl/dds_top_if.sv
// -----------------------------------------------------------------------------
// dds_top_if
// Bundles the DDS control inputs and the DAC output pins into one interface.
//
//   dds_en     : 1 = phase accumulator advances, 0 = holds
//   f_word     : frequency tuning word, f_out = f_sys * f_word / 2^ACC_W
//   p_word     : phase offset, 2^ADDR_W = one full cycle
//   wave_type  : 0 sine, 1 square, 2 triangle, 3 sawtooth
//   clk_da     : DAC sample clock (inverted system clock)
//   da_data    : DAC sample, offset binary
//
// master modport: the side that drives the controls and receives DAC pins.
// slave modport : the DDS core.
// -----------------------------------------------------------------------------
interface dds_top_if #(
  parameter int ACC_W  = 32,
  parameter int ADDR_W = 12,
  parameter int DATA_W = 8
) ();

  logic              dds_en;
  logic [ACC_W-1:0]  f_word;
  logic [ADDR_W-1:0] p_word;
  logic [1:0]        wave_type;
  logic              clk_da;
  logic [DATA_W-1:0] da_data;

  modport master (
    output dds_en, f_word, p_word, wave_type,
    input  clk_da, da_data
  );

  modport slave (
    input  dds_en, f_word, p_word, wave_type,
    output clk_da, da_data
  );

endinterface

// File: rtl/dds_top.sv
// -----------------------------------------------------------------------------
// dds_top
// Direct digital synthesis generator for an 8-bit parallel DAC.
// Three register stages:
//   acc  : phase accumulator, acc += f_word while dds_en = 1
//   addr : acc[31:20] + p_word (updates every cycle, even when disabled)
//   data : waveform lookup of addr selected by wave_type
// clk_da is the inverted system clock so the DAC samples mid-cycle.
//
// Ports:
//   sys_clk    : system clock, rising edge
//   sys_rst_n  : asynchronous active-low reset (acc, addr, da_data -> 0)
//   bus        : dds_top_if.slave (dds_en, f_word, p_word, wave_type,
//                clk_da, da_data)
//
// Optional build macro:
//   DDS_SYNC_CLR_EN : when defined, acc is cleared on every edge while
//                     dds_en = 0, so re-enabling restarts at phase p_word.
//                     When undefined, acc simply holds.
// -----------------------------------------------------------------------------
module dds_top #(
  parameter int ACC_W  = 32,
  parameter int ADDR_W = 12,
  parameter int DATA_W = 8
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  dds_top_if.slave   bus
);

  logic [ACC_W-1:0]  acc_q,  acc_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;

  logic [7:0]        sine_idx;
  logic [6:0]        qtr_k;
  logic [6:0]        qtr_v;
  logic [DATA_W-1:0] sine_val;

  // floor(127.5 * sin(2*pi*k/256)) for k = 0..64.
  // Positive half-cycle: 128 + q. Negative half: 127 - q, except the exact
  // zero crossing (k = 0), where round-half-up of 127.5 gives 128.
  function automatic logic [6:0] qtr_sine(input logic [6:0] k);
    logic [6:0] v;
    case (k)
      7'd0:  v = 7'd0;   7'd1:  v = 7'd3;   7'd2:  v = 7'd6;   7'd3:  v = 7'd9;
      7'd4:  v = 7'd12;  7'd5:  v = 7'd15;  7'd6:  v = 7'd18;  7'd7:  v = 7'd21;
      7'd8:  v = 7'd24;  7'd9:  v = 7'd27;  7'd10: v = 7'd30;  7'd11: v = 7'd34;
      7'd12: v = 7'd37;  7'd13: v = 7'd39;  7'd14: v = 7'd42;  7'd15: v = 7'd45;
      7'd16: v = 7'd48;  7'd17: v = 7'd51;  7'd18: v = 7'd54;  7'd19: v = 7'd57;
      7'd20: v = 7'd60;  7'd21: v = 7'd62;  7'd22: v = 7'd65;  7'd23: v = 7'd68;
      7'd24: v = 7'd70;  7'd25: v = 7'd73;  7'd26: v = 7'd75;  7'd27: v = 7'd78;
      7'd28: v = 7'd80;  7'd29: v = 7'd83;  7'd30: v = 7'd85;  7'd31: v = 7'd87;
      7'd32: v = 7'd90;  7'd33: v = 7'd92;  7'd34: v = 7'd94;  7'd35: v = 7'd96;
      7'd36: v = 7'd98;  7'd37: v = 7'd100; 7'd38: v = 7'd102; 7'd39: v = 7'd104;
      7'd40: v = 7'd106; 7'd41: v = 7'd107; 7'd42: v = 7'd109; 7'd43: v = 7'd110;
      7'd44: v = 7'd112; 7'd45: v = 7'd113; 7'd46: v = 7'd115; 7'd47: v = 7'd116;
      7'd48: v = 7'd117; 7'd49: v = 7'd118; 7'd50: v = 7'd120; 7'd51: v = 7'd121;
      7'd52: v = 7'd122; 7'd53: v = 7'd122; 7'd54: v = 7'd123; 7'd55: v = 7'd124;
      7'd56: v = 7'd125; 7'd57: v = 7'd125; 7'd58: v = 7'd126; 7'd59: v = 7'd126;
      7'd60: v = 7'd126; 7'd61: v = 7'd127; 7'd62: v = 7'd127; 7'd63: v = 7'd127;
      default: v = 7'd127;
    endcase
    return v;
  endfunction

  // Stage 1: accumulator, natural modulo-2^ACC_W wrap
  always_comb begin
    acc_d = acc_q;
    if (bus.dds_en) begin
      acc_d = acc_q + bus.f_word;
    end
`ifdef DDS_SYNC_CLR_EN
    else begin
      acc_d = '0;
    end
`endif
  end

  // Stage 2: phase address, modulo 2^ADDR_W by truncation
  always_comb begin
    addr_d = acc_q[ACC_W-1 -: ADDR_W] + bus.p_word;
  end

  // Sine via quarter-wave symmetry; second and fourth quarters mirror the index.
  always_comb begin
    sine_idx = addr_q[ADDR_W-1 -: 8];
    qtr_k    = sine_idx[6] ? (7'd64 - {1'b0, sine_idx[5:0]}) : {1'b0, sine_idx[5:0]};
    qtr_v    = qtr_sine(qtr_k);
    if (!sine_idx[7]) begin
      sine_val = 8'd128 + {1'b0, qtr_v};
    end else if (qtr_k == 7'd0) begin
      sine_val = 8'd128;
    end else begin
      sine_val = 8'd127 - {1'b0, qtr_v};
    end
  end

  // Stage 3: waveform select
  always_comb begin
    data_d = '0;
    case (bus.wave_type)
      2'd0: data_d = sine_val;
      2'd1: data_d = addr_q[ADDR_W-1] ? '0 : '1;
      2'd2: data_d = addr_q[ADDR_W-1] ? ~addr_q[ADDR_W-2 -: DATA_W]
                                      :  addr_q[ADDR_W-2 -: DATA_W];
      default: data_d = addr_q[ADDR_W-1 -: DATA_W];
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      acc_q  <= '0;
      addr_q <= '0;
      data_q <= '0;
    end else begin
      acc_q  <= acc_d;
      addr_q <= addr_d;
      data_q <= data_d;
    end
  end

  assign bus.da_data = data_q;
  assign bus.clk_da  = ~sys_clk;

endmodule

// File: tb/tb_dds_top.sv
// -----------------------------------------------------------------------------
// tb_dds_top
// Randomized and directed stimulus for dds_top, checked every cycle against a
// behavioural model that computes the expected sample from the phase
// arithmetic and the closed-form waveform definitions (sine via $sin).
// -----------------------------------------------------------------------------
module tb_dds_top;

  localparam real PI = 3.14159265358979323846;

  logic sys_clk;
  logic sys_rst_n;

  dds_top_if bus_if ();

  dds_top dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .bus       (bus_if.slave)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  int     n_cmp = 0;
  int     n_err = 0;

  // model state: phase accumulator, latched phase address, latched sample
  longint m_acc  = 0;
  int     m_addr = 0;
  int     m_out  = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int wave_ref(input int addr, input int wt);
    int  i;
    real s;
    case (wt)
      0: begin
        i = addr / 16;
        s = 127.5 + 127.5 * $sin(2.0 * PI * i / 256.0);
        return int'($floor(s + 0.5));
      end
      1: return (addr < 2048) ? 255 : 0;
      2: return (addr < 2048) ? (addr / 8) : (255 - (addr - 2048) / 8);
      default: return addr / 16;
    endcase
  endfunction

  task automatic model_reset();
    m_acc  = 0;
    m_addr = 0;
    m_out  = 0;
  endtask

  // One clock: advance the model with the inputs present at the edge,
  // then compare on the falling edge.
  task automatic tick(input string tag);
    @(posedge sys_clk);
    if (sys_rst_n) begin
      m_out  = wave_ref(m_addr, int'(bus_if.wave_type));
      m_addr = int'(((m_acc >> 20) + longint'(bus_if.p_word)) % 4096);
      if (bus_if.dds_en)
        m_acc = (m_acc + longint'(bus_if.f_word)) & 64'hFFFF_FFFF;
`ifdef DDS_SYNC_CLR_EN
      else
        m_acc = 0;
`endif
    end
    @(negedge sys_clk);
    chk(tag, 64'(bus_if.da_data), 64'(m_out));
  endtask

  task automatic run(input string tag, input int n);
    for (int k = 0; k < n; k++) tick(tag);
  endtask

  initial begin
    sys_rst_n        = 1'b0;
    bus_if.dds_en    = 1'b0;
    bus_if.f_word    = 32'h1234_5678;
    bus_if.p_word    = 12'h000;
    bus_if.wave_type = 2'd0;
    model_reset();

    // reset state, including clocks while reset is held
    #2;
    chk("rst_data", 64'(bus_if.da_data), 64'd0);
    run("rst_hold", 3);
    chk("clk_da_lo", 64'(bus_if.clk_da), 64'd1);
    @(posedge sys_clk); #1;
    chk("clk_da_hi", 64'(bus_if.clk_da), 64'd0);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;

    // disabled, sine, phase 0 -> constant 128
    run("idle_sine", 8);
    chk("idle_const", 64'(bus_if.da_data), 64'd128);

    // sawtooth ramp
    bus_if.wave_type = 2'd3;
    bus_if.f_word    = 32'h0100_0000;
    bus_if.dds_en    = 1'b1;
    run("saw", 300);

    // hold mid-ramp, then resume
    bus_if.dds_en = 1'b0;
    run("saw_hold", 20);
    bus_if.dds_en = 1'b1;
    run("saw_resume", 20);

    // square, then inverted by half-cycle phase offset
    bus_if.wave_type = 2'd1;
    bus_if.f_word    = 32'h1000_0000;
    run("square", 40);
    bus_if.p_word = 12'h800;
    run("square_p800", 40);
    bus_if.p_word = 12'h000;

    // sine checkpoints and a near-8-sample-per-cycle tone
    bus_if.wave_type = 2'd0;
    bus_if.f_word    = 32'h0400_0000;
    run("sine_q", 24);
    bus_if.f_word = 32'h1FFF_FFFF;
    run("sine_fast", 40);

    // triangle over two full periods
    bus_if.wave_type = 2'd2;
    bus_if.f_word    = 32'h0080_0000;
    run("tri", 1030);

    // aliasing word
    bus_if.f_word = 32'hC000_0001;
    run("alias", 30);

    // asynchronous reset mid-run
    @(posedge sys_clk); #2;
    sys_rst_n = 1'b0;
    #1;
    chk("async_rst", 64'(bus_if.da_data), 64'd0);
    model_reset();
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    run("post_rst", 10);

    // randomized stimulus
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 15) == 0)
        bus_if.f_word = ($urandom_range(0, 1) == 0) ? $urandom : ($urandom & 32'h03FF_FFFF);
      if ($urandom_range(0, 31) == 0) bus_if.p_word    = 12'($urandom);
      if ($urandom_range(0, 23) == 0) bus_if.wave_type = 2'($urandom);
      if ($urandom_range(0, 19) == 0) bus_if.dds_en    = ~bus_if.dds_en;
      tick("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
